serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 133 +++++++++++++
 tb/tb_serial_subtractor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b, LSB first, registered borrow) with start/done handshake.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow_out,
    output logic [1:0]       o_state
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sd;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             w_d;
    logic             w_br_nxt;
    logic             w_last;
    logic [WIDTH-1:0] w_sd_nxt;

`ifdef SERIAL_SUB_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;
`endif

    // One full-subtractor slice on the current LSBs.
    assign w_d      = r_sa[0] ^ r_sb[0] ^ r_br;
    assign w_br_nxt = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
    assign w_last   = (r_cnt == LAST_CNT);
    assign w_sd_nxt = {w_d, r_sd[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa         <= '0;
            r_sb         <= '0;
            r_sd         <= '0;
            r_br         <= 1'b0;
            r_cnt        <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb      <= 1'b0;
            r_b_msb      <= 1'b0;
            r_ovf        <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_sa  <= i_a;
                        r_sb  <= i_b;
                        r_sd  <= '0;
                        r_br  <= 1'b0;
                        r_cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        r_a_msb <= i_a[WIDTH-1];
                        r_b_msb <= i_b[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_sd  <= w_sd_nxt;
                    r_br  <= w_br_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    // Outputs only change here, so partial shift state never leaks out.
                    if (w_last) begin
                        r_diff       <= w_sd_nxt;
                        r_borrow_out <= w_br_nxt;
`ifdef SERIAL_SUB_OVF_EN
                        r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy       = (r_state == S_RUN);
    assign o_done       = (r_state == S_DONE);
    assign o_diff       = r_diff;
    assign o_borrow_out = r_borrow_out;
    assign o_state      = r_state;
`ifdef SERIAL_SUB_OVF_EN
    assign o_ovf        = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: driver pushes expected {ovf,borrow,diff} and done time,
// a negedge monitor pops and compares whenever done is presented.
`timescale 1ns/1ps
module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam time CLK_P = 10;

    logic             clk;
    logic             rst_n;
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_diff;
    logic             o_borrow_out;
    logic [1:0]       o_state;
`ifdef SERIAL_SUB_OVF_EN
    logic             o_ovf;
`endif

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_a          (i_a),
        .i_b          (i_b),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_diff       (o_diff),
        .o_borrow_out (o_borrow_out),
        .o_state      (o_state)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .o_ovf        (o_ovf)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #(CLK_P / 2) clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard
    logic [WIDTH+1:0] exp_q[$];
    time              exp_t_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] last_diff = '0;
    logic             last_bo   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [WIDTH+1:0] e;
        time              et;
        if (rst_n && o_done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected none at %0t", $time);
            end else begin
                e  = exp_q.pop_front();
                et = exp_t_q.pop_front();
                check("diff", 32'(o_diff), 32'(e[WIDTH-1:0]));
                check("borrow_out", 32'(o_borrow_out), 32'(e[WIDTH]));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(o_ovf), 32'(e[WIDTH+1]));
`endif
                check("done_time", 32'($time), 32'(et));
            end
        end
    end

    // Driver: one full operation, with busy-length and output-stability checks.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
        int  busy_cnt;
        bit  seen;
        @(negedge clk);
        i_a     = a;
        i_b     = b;
        i_start = 1'b1;
        @(posedge clk);
        exp_q.push_back({eo, eb, ed});
        exp_t_q.push_back($time + WIDTH * CLK_P + CLK_P / 2);
        @(negedge clk);
        i_start  = 1'b0;
        i_a      = WIDTH'($urandom_range(0, 255));
        i_b      = WIDTH'($urandom_range(0, 255));
        busy_cnt = 0;
        seen     = 1'b0;
        for (int k = 0; k < 2 * WIDTH + 4 && !seen; k++) begin
            if (o_done) begin
                seen = 1'b1;
                check("busy_at_done", 32'(o_busy), 32'(0));
            end else begin
                if (o_busy) busy_cnt++;
                check("diff_held", 32'(o_diff), 32'(last_diff));
                check("borrow_held", 32'(o_borrow_out), 32'(last_bo));
                @(negedge clk);
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", 2 * WIDTH + 4);
        end
        check("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
        last_diff = ed;
        last_bo   = eb;
    endtask

    initial begin
        int  ndone;
        time t0;
        rst_n   = 1'b1;
        i_start = 1'b0;
        i_a     = '0;
        i_b     = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_diff", 32'(o_diff), 32'(0));
        check("rst_borrow", 32'(o_borrow_out), 32'(0));
        check("rst_busy", 32'(o_busy), 32'(0));
        check("rst_done", 32'(o_done), 32'(0));
        check("rst_state", 32'(o_state), 32'(0));
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", 32'(o_ovf), 32'(0));
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
        run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

        // Start held through RUN and DONE: ignored, then re-accepted two edges after the last bit.
        @(negedge clk);
        i_a     = 8'h05;
        i_b     = 8'h03;
        i_start = 1'b1;
        @(posedge clk);
        t0 = $time;
        exp_q.push_back({1'b0, 1'b0, 8'h02});
        exp_t_q.push_back(t0 + WIDTH * CLK_P + CLK_P / 2);
        exp_q.push_back({1'b0, 1'b0, 8'h99});
        exp_t_q.push_back(t0 + (WIDTH + 2) * CLK_P + WIDTH * CLK_P + CLK_P / 2);
        @(negedge clk);
        i_a   = 8'hAA;
        i_b   = 8'h11;
        ndone = 0;
        for (int k = 0; k < 4 * WIDTH + 8 && ndone < 2; k++) begin
            if (o_done) ndone++;
            if (ndone < 2) @(negedge clk);
        end
        i_start = 1'b0;
        check("held_start_dones", 32'(ndone), 32'(2));
        last_diff = 8'h99;
        last_bo   = 1'b0;

        // Stability of the previous result is checked every cycle inside run_op.
        run_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);

        // Reset in the middle of RUN.
        @(negedge clk);
        i_a     = 8'h12;
        i_b     = 8'h34;
        i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_diff", 32'(o_diff), 32'(0));
        check("abort_borrow", 32'(o_borrow_out), 32'(0));
        check("abort_busy", 32'(o_busy), 32'(0));
        check("abort_state", 32'(o_state), 32'(0));
`ifdef SERIAL_SUB_OVF_EN
        check("abort_ovf", 32'(o_ovf), 32'(0));
`endif
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(o_done), 32'(0));
        end
        rst_n     = 1'b1;
        last_diff = '0;
        last_bo   = 1'b0;
        run_op(8'h80, 8'h7F, 8'h01, 1'b0, 1'b1);

        // Signed-overflow vectors (diff/borrow checked in every build).
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        run_op(8'h30, 8'h10, 8'h20, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("pending_results", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
